// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with gray-coded pointer synchronisers, local fill counts and almost-full/empty flags.
// Define ASYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module async_fifo_lvl #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic                  wr_clk,
    input  logic                  wr_reset,
    input  logic                  rd_clk,
    input  logic                  rd_reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [AW:0]           wr_count,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [AW:0]           rd_count
`ifdef ASYNC_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    // Gray bits to invert when comparing write pointer against the synchronised read pointer for full.
    localparam logic [AW:0] FULL_MASK = (AW + 1)'(2'b11) << (AW - 1);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
        return b;
    endfunction

    logic [DATA_WIDTH-1:0]        r_mem [DEPTH];
    logic [AW:0]                  r_wr_bin, r_wr_gray;
    logic [AW:0]                  r_rd_bin, r_rd_gray;
    logic [SYNC_STAGES-1:0][AW:0] r_rd_sync;
    logic [SYNC_STAGES-1:0][AW:0] r_wr_sync;

    logic [AW:0] w_rd_gray_s, w_wr_gray_s;
    logic [AW:0] w_wr_bin_next, w_rd_bin_next;
    logic        w_wr_accept, w_rd_accept;

    assign w_rd_gray_s   = r_rd_sync[SYNC_STAGES-1];
    assign w_wr_gray_s   = r_wr_sync[SYNC_STAGES-1];
    assign w_wr_accept   = wr_en && !full;
    assign w_rd_accept   = rd_en && !empty;
    assign w_wr_bin_next = r_wr_bin + 1'b1;
    assign w_rd_bin_next = r_rd_bin + 1'b1;

    // ---------------- write domain ----------------
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wr_clk or posedge wr_reset) begin
        if (wr_reset) begin
            r_wr_bin  <= '0;
            r_wr_gray <= '0;
            r_rd_sync <= '0;
        end else begin
            r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], r_rd_gray};
            if (w_wr_accept) begin
                r_wr_bin  <= w_wr_bin_next;
                r_wr_gray <= bin2gray(w_wr_bin_next);
            end
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which words are valid.
    always_ff @(posedge wr_clk) begin
        if (w_wr_accept) r_mem[r_wr_bin[AW-1:0]] <= wr_data;
    end

    assign full        = (r_wr_gray == (w_rd_gray_s ^ FULL_MASK));
    assign wr_count    = r_wr_bin - gray2bin(w_rd_gray_s);
    assign almost_full = (wr_count >= (AW + 1)'(AFULL_THRESH));

    // ---------------- read domain ----------------
    always_ff @(posedge rd_clk or posedge rd_reset) begin
        if (rd_reset) begin
            r_rd_bin  <= '0;
            r_rd_gray <= '0;
            r_wr_sync <= '0;
            rd_data   <= '0;
        end else begin
            r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], r_wr_gray};
            if (w_rd_accept) begin
                rd_data   <= r_mem[r_rd_bin[AW-1:0]];
                r_rd_bin  <= w_rd_bin_next;
                r_rd_gray <= bin2gray(w_rd_bin_next);
            end
        end
    end

    assign empty        = (r_rd_gray == w_wr_gray_s);
    assign rd_count     = gray2bin(w_wr_gray_s) - r_rd_bin;
    assign almost_empty = (rd_count <= (AW + 1)'(AEMPTY_THRESH));

`ifdef ASYNC_FIFO_ERR_EN
    always_ff @(posedge wr_clk or posedge wr_reset) begin
        if (wr_reset)           overflow <= 1'b0;
        else if (wr_en && full) overflow <= 1'b1;
    end

    always_ff @(posedge rd_clk or posedge rd_reset) begin
        if (rd_reset)            underflow <= 1'b0;
        else if (rd_en && empty) underflow <= 1'b1;
    end
`endif

endmodule

// File: doc/async_fifo_lvl.md
# async_fifo_lvl

Parametrised dual-clock FIFO that carries data words from a write clock domain to an unrelated read clock domain. Gray-coded pointers cross domains through synchroniser chains of configurable length. Each side has a local fill count and programmable almost-full/almost-empty flags. It replaces fixed two-stage async FIFOs at clock-domain boundaries where the producer needs back-pressure before the FIFO is fully full.

## Interface
- DATA_WIDTH, 8, width of a data word
- DEPTH, 16, number of storage words; power of two, ≥ 2
- SYNC_STAGES, 2, flops per pointer synchroniser; legal 2..4
- AFULL_THRESH, DEPTH-2, almost_full asserts when wr_count ≥ this value; legal 1..DEPTH
- AEMPTY_THRESH, 1, almost_empty asserts when rd_count ≤ this value; legal 0..DEPTH-1
- Derived: AW = $clog2(DEPTH); pointers are AW+1 bits.
- wr_clk  in  1  write-domain clock
- wr_reset  in  1  write-domain reset; asynchronous, active-high
- rd_clk  in  1  read-domain clock
- rd_reset  in  1  read-domain reset; asynchronous, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- full  out  1  write side: DEPTH words stored
- almost_full  out  1  write side: wr_count ≥ AFULL_THRESH
- wr_count  out  AW+1  write-side fill level, 0..DEPTH
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  registered read word
- empty  out  1  read side: no word available
- almost_empty  out  1  read side: rd_count ≤ AEMPTY_THRESH
- rd_count  out  AW+1  read-side fill level, 0..DEPTH
- overflow  out  1  sticky; present only with ASYNC_FIFO_ERR_EN
- underflow  out  1  sticky; present only with ASYNC_FIFO_ERR_EN

## Operation
- Write is accepted when wr_en && !full at the wr_clk edge. On accept, mem[wr_bin[AW-1:0]] ← wr_data, wr_bin increments, and wr_gray ← bin2gray(wr_bin+1). All of these are registered.
- Read is accepted when rd_en && !empty at the rd_clk edge. On accept, rd_data ← mem[rd_bin[AW-1:0]], rd_bin increments, and rd_gray is updated the same way. rd_data holds its value when no read is accepted.
- wr_gray passes through SYNC_STAGES rd_clk flops to give wr_gray_s. rd_gray passes through SYNC_STAGES wr_clk flops to give rd_gray_s. Only the gray registers cross domains.
- full = (wr_gray == {~rd_gray_s[AW:AW-1], rd_gray_s[AW-2:0]}). For AW=1, both bits are inverted.
- empty = (rd_gray == wr_gray_s).
- wr_count = wr_bin − gray2bin(rd_gray_s), modulo 2^(AW+1).
- rd_count = gray2bin(wr_gray_s) − rd_bin, modulo 2^(AW+1).
- Flags and counts are combinational from local-domain flops only. They are pessimistic: full, almost_full and wr_count may overstate the fill level; empty, almost_empty and rd_count may understate it. They never err in the unsafe direction.
- Write with full is dropped. Read with empty is ignored. Pointers and memory are unchanged in both cases.
- Pointer wrap: the AW+1-bit pointers wrap naturally. The MSB distinguishes full from empty.

## Timing
- Reset values: full=0, almost_full=0, wr_count=0, empty=1, almost_empty=1, rd_count=0, rd_data=0, overflow=0, underflow=0.
- wr_reset clears wr_bin, wr_gray and the rd_gray_s chain. rd_reset clears rd_bin, rd_gray, rd_data and the wr_gray_s chain. Memory is not reset.
- Reset mid-operation: both resets must overlap for a flush. After both deassert, the FIFO is empty and stored words are discarded. Asserting only one reset while traffic is flowing is unsupported.
- Read-side visibility of a write: empty deasserts SYNC_STAGES to SYNC_STAGES+1 rd_clk edges after the wr_clk edge that accepted the write.
- Write-side visibility of a read: full and wr_count update SYNC_STAGES to SYNC_STAGES+1 wr_clk edges after the accepting rd_clk edge.
- Read latency: rd_data is valid on the rd_clk edge that accepts rd_en.
- Simultaneous read and write on a non-empty, non-full FIFO: both are accepted.

## Configuration
- ASYNC_FIFO_ERR_EN defined: overflow and underflow ports exist.
  - overflow sets on the wr_clk edge where wr_en && full. It stays set until wr_reset.
  - underflow sets on the rd_clk edge where rd_en && empty. It stays set until rd_reset.
- ASYNC_FIFO_ERR_EN undefined: the ports and their logic are absent. The drop/ignore behaviour is unchanged.

## Test plan
Bench settings: DATA_WIDTH=8, DEPTH=8, SYNC_STAGES=2, AFULL_THRESH=6, AEMPTY_THRESH=1, wr_clk period 10 ns, rd_clk period 17 ns.
- Reset: pulse both resets, then idle → full=0, empty=1, almost_empty=1, counts=0, rd_data=0.
- Fill: write 0x01..0x08 with no reads → almost_full asserts after the 6th write, full asserts after the 8th, wr_count=8. A 9th write of 0xFF is dropped and overflow=1 (ERR_EN defined).
- Drain: read 8 times → rd_data sequence is 0x01..0x08. empty asserts after the 8th read. A 9th read leaves rd_data=0x08 and sets underflow=1.
- Latency: a single write into the empty FIFO → empty deasserts within 2–3 rd_clk edges, and rd_count becomes 1 with almost_empty=1.
- Wrap: stream 100 words 0x00..0x63 with random wr_en/rd_en at both clock ratios (10/17 ns and 17/10 ns) → output order is exact, no loss, full and empty never violated.
- Mid-run flush: assert both resets with 5 words stored → after release empty=1, counts=0; a following write of 0xA5 is read back as 0xA5.
